// File: rtl/rv523_serial_alu.sv
// Bit-serial ALU: one full-adder slice, LSB first; DONE pulses WIDTH+1 cycles after an accepted START.
// START is honoured only while READY (IDLE/FIN); requests while BUSY are dropped, not queued.
module rv523_serial_alu #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 5
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             READY,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SLT  = 3'd5;
   localparam logic [2:0] OP_SLTU = 3'd6;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [2:0]       opr;
   logic [CNTW-1:0]  cnt;
   logic             carry;

   logic a_bit, b_raw, b_eff, sum, cout, r_bit, lt, last;

   function automatic logic is_sub(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
   endfunction

   always_comb begin
      a_bit = sa[0];
      b_raw = sb[0];
      b_eff = b_raw ^ is_sub(opr);
      sum   = a_bit ^ b_eff ^ carry;
      cout  = (a_bit & b_eff) | (carry & (a_bit ^ b_eff));
      last  = (cnt == CNTW'(WIDTH - 1));
      r_bit = 1'b0;
      case (opr)
         OP_ADD, OP_SUB: r_bit = sum;
         OP_AND:         r_bit = a_bit & b_raw;
         OP_OR:          r_bit = a_bit | b_raw;
         OP_XOR:         r_bit = a_bit ^ b_raw;
         default:        r_bit = 1'b0;
      endcase
      // Signed compare: differing sign bits decide directly, otherwise the difference's sign does.
      lt = 1'b0;
      if (opr == OP_SLT)
         lt = (a_bit != b_raw) ? a_bit : sum;
      else if (opr == OP_SLTU)
         lt = ~cout;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state  <= S_IDLE;
         READY  <= 1'b1;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         RESULT <= '0;
         sa     <= '0;
         sb     <= '0;
         opr    <= OP_ADD;
         cnt    <= '0;
         carry  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FIN: begin
               DONE <= 1'b0;
               if (START) begin
                  state <= S_RUN;
                  READY <= 1'b0;
                  BUSY  <= 1'b1;
                  sa    <= A;
                  sb    <= B;
                  opr   <= OP;
                  cnt   <= '0;
                  carry <= is_sub(OP);
               end else begin
                  state <= S_IDLE;
                  READY <= 1'b1;
                  BUSY  <= 1'b0;
               end
            end
            S_RUN: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               cnt   <= cnt + CNTW'(1);
               carry <= cout;
               if (last) begin
                  state <= S_FIN;
                  READY <= 1'b1;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  if ((opr == OP_SLT) || (opr == OP_SLTU))
                     RESULT <= {{(WIDTH-1){1'b0}}, lt};
                  else
                     RESULT <= {r_bit, RESULT[WIDTH-1:1]};
               end else begin
                  RESULT <= {r_bit, RESULT[WIDTH-1:1]};
               end
            end
            default: begin
               state <= S_IDLE;
               READY <= 1'b1;
               BUSY  <= 1'b0;
               DONE  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv523_serial_alu.sv
// Bench for rv523_serial_alu: transaction-level model plus directed vectors with literal results.
module tb_rv523_serial_alu;
   localparam int WIDTH = 32;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              START = 1'b0;
   logic [2:0]        OP = 3'd0;
   logic [WIDTH-1:0]  A = '0;
   logic [WIDTH-1:0]  B = '0;
   logic              READY, BUSY, DONE;
   logic [WIDTH-1:0]  RESULT;

   int errors = 0;
   int checks = 0;

   rv523_serial_alu #(.WIDTH(WIDTH), .CNTW(5)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .A(A), .B(B),
      .READY(READY), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [WIDTH-1:0] golden(input logic [2:0] op, input logic [WIDTH-1:0] a, b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
         3'd6: return (a < b) ? 1 : 0;
         default: return '0;
      endcase
   endfunction

   task automatic check(input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp, input string nm);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Transaction model: an accepted request occupies WIDTH cycles, then one DONE cycle.
   logic             m_busy = 1'b0;
   logic             m_done = 1'b0;
   logic [WIDTH-1:0] m_result = '0;
   logic [WIDTH-1:0] m_pending = '0;
   int               m_left = 0;

   always @(posedge CLK) begin
      if (!RST_N) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_result <= '0; m_left <= 0;
      end else if (m_busy) begin
         m_done <= (m_left == 1);
         if (m_left == 1) begin
            m_busy   <= 1'b0;
            m_result <= m_pending;
         end
         m_left <= m_left - 1;
      end else begin
         m_done <= 1'b0;
         if (START) begin
            m_busy    <= 1'b1;
            m_left    <= WIDTH;
            m_pending <= golden(OP, A, B);
         end
      end
   end

   always @(posedge CLK) begin
      #1;
      check({31'd0, READY}, {31'd0, !m_busy}, "ready");
      check({31'd0, BUSY}, {31'd0, m_busy}, "busy");
      check({31'd0, DONE}, {31'd0, m_done}, "done");
      if (!m_busy) check(RESULT, m_result, "result_hold");
   end

   task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, b);
      @(negedge CLK); START = 1'b1; OP = op; A = a; B = b;
      @(negedge CLK); START = 1'b0;
   endtask

   // Waits for DONE; exp_lat is the number of negedges expected after the call starts.
   task automatic wait_done(input logic [WIDTH-1:0] exp, input int exp_lat, input string nm, output int busy_n);
      int lat = 0;
      busy_n = BUSY ? 1 : 0;
      for (int i = 1; i <= 100 && lat == 0; i++) begin
         @(negedge CLK);
         if (BUSY) busy_n++;
         if (DONE) lat = i;
      end
      if (lat == 0) begin
         errors++; checks++;
         $display("FAIL %s_timeout actual=no_done required=done", nm);
      end else begin
         check(lat, exp_lat, {nm, "_latency"});
         check(RESULT, exp, {nm, "_result"});
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] a, b, exp, input string nm);
      int busy_n;
      check(golden(op, a, b), exp, {nm, "_model"});
      issue(op, a, b);
      wait_done(exp, WIDTH, nm, busy_n);
      check(busy_n, WIDTH, {nm, "_busy_cycles"});
   endtask

   initial begin
      int busy_n;
      repeat (3) @(negedge CLK);
      check({31'd0, READY}, 32'd1, "reset_ready");
      check({31'd0, BUSY}, 32'd0, "reset_busy");
      check(RESULT, 32'd0, "reset_result");
      RST_N = 1'b1;
      @(negedge CLK);

      run_op(3'd0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, "add_5_3");
      run_op(3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap");
      run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap");
      run_op(3'd1, 32'h0000_0064, 32'h0000_001E, 32'h0000_0046, "sub_100_30");
      run_op(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_m1_1");
      run_op(3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu_max_1");
      run_op(3'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "slt_1_m1");
      run_op(3'd6, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, "sltu_1_max");
      run_op(3'd5, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "slt_eq");
      run_op(3'd6, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "sltu_eq");
      run_op(3'd5, 32'h0000_0003, 32'h0000_0007, 32'h0000_0001, "slt_3_7");
      run_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, "and");
      run_op(3'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, "or");
      run_op(3'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, "xor");
      run_op(3'd7, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0000_0000, "op7");

      // START during RUN must be dropped.
      issue(3'd0, 32'h0000_0005, 32'h0000_0003);
      repeat (10) @(negedge CLK);
      START = 1'b1; OP = 3'd4; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
      @(negedge CLK); START = 1'b0;
      wait_done(32'h0000_0008, WIDTH - 11, "midrun_start", busy_n);

      // START raised in the DONE cycle chains straight into the next operation.
      issue(3'd3, 32'h0000_00F0, 32'h0000_000F);
      wait_done(32'h0000_00FF, WIDTH, "chain_first", busy_n);
      START = 1'b1; OP = 3'd1; A = 32'h0000_0010; B = 32'h0000_0020;
      @(negedge CLK); START = 1'b0;
      check({31'd0, BUSY}, 32'd1, "chain_no_gap");
      check(RESULT, 32'h0000_00FF, "chain_result_held");
      wait_done(32'hFFFF_FFF0, WIDTH, "chain_second", busy_n);

      // Reset in the middle of RUN aborts without DONE.
      issue(3'd0, 32'h0000_0005, 32'h0000_0003);
      repeat (9) @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK); RST_N = 1'b1;
      check({31'd0, READY}, 32'd1, "abort_ready");
      check({31'd0, BUSY}, 32'd0, "abort_busy");
      check({31'd0, DONE}, 32'd0, "abort_done");
      check(RESULT, 32'd0, "abort_result");
      repeat (WIDTH + 2) @(negedge CLK);
      run_op(3'd0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, "add_after_abort");

      repeat (3) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
